// File: rtl/div_ctrl_pkg.sv
// Shared encodings and op decode helpers for the RV32M divide sequencer.
package div_ctrl_pkg;

    localparam logic [6:0] INST_TYPE_M_FUNCT7 = 7'b0000001;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam int unsigned DIV_ITER_LAST = 31;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'b00,
        DIV_STATE_CALC = 2'b01,
        DIV_STATE_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quot_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quot_o
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [DATA_WIDTH:0] rem_sh;
    logic [DATA_WIDTH:0] diff;

    assign rem_sh = {rem_i, quot_i[DATA_WIDTH-1]};
    assign diff   = rem_sh - {1'b0, divisor_i};
    assign rem_o  = diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign quot_o = {quot_i[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: stalls exe while iterating, then
// emits a single write-back beat.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  dividend_i,
    input  logic [DATA_WIDTH-1:0]  divisor_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   stall_o,
    output logic                   result_valid_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic neg,
                                                       input logic [DATA_WIDTH-1:0] x);
        return neg ? (~x + DATA_WIDTH'(1)) : x;
    endfunction

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0]  quot_q, quot_d;
    logic [DATA_WIDTH-1:0]  dvsr_q, dvsr_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;

    logic [DATA_WIDTH-1:0]  step_rem, step_quot;
    logic                   in_signed, dvd_neg, dvs_neg, div_zero, sgn_ovf;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    assign in_signed = op_is_signed(op_i);
    assign dvd_neg   = in_signed & dividend_i[DATA_WIDTH-1];
    assign dvs_neg   = in_signed & divisor_i[DATA_WIDTH-1];
    assign div_zero  = (divisor_i == '0);
    assign sgn_ovf   = in_signed & (dividend_i == MOST_NEG) & (&divisor_i);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        waddr_d        = waddr_q;
        rem_d          = rem_q;
        quot_d         = quot_q;
        dvsr_d         = dvsr_q;
        neg_quot_d     = neg_quot_q;
        neg_rem_d      = neg_rem_q;
        result_d       = result_q;
        reg_waddr_d    = reg_waddr_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;

        case (state_q)
            DIV_STATE_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o    = 1'b1;
                    op_d       = op_i;
                    waddr_d    = reg_waddr_i;
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    rem_d      = '0;
                    quot_d     = cond_neg(dvd_neg, dividend_i);
                    dvsr_d     = cond_neg(dvs_neg, divisor_i);
                    cnt_d      = '0;
                    // Special cases bypass the iteration and answer next cycle.
                    if (div_zero) begin
                        result_d    = op_is_rem(op_i) ? dividend_i : '1;
                        reg_waddr_d = reg_waddr_i;
                        state_d     = DIV_STATE_DONE;
                    end else if (sgn_ovf) begin
                        result_d    = op_is_rem(op_i) ? '0 : MOST_NEG;
                        reg_waddr_d = reg_waddr_i;
                        state_d     = DIV_STATE_DONE;
                    end else begin
                        state_d = DIV_STATE_CALC;
                    end
                end
            end
            DIV_STATE_CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = DIV_STATE_IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d    = op_is_rem(op_q) ? cond_neg(neg_rem_q, step_rem)
                                                      : cond_neg(neg_quot_q, step_quot);
                        reg_waddr_d = waddr_q;
                        state_d     = DIV_STATE_DONE;
                    end
                end
            end
            DIV_STATE_DONE: begin
                result_valid_o = ~flush_i;
                state_d        = DIV_STATE_IDLE;
            end
            default: state_d = DIV_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= DIV_STATE_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            waddr_q     <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            reg_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            waddr_q     <= waddr_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            reg_waddr_q <= reg_waddr_d;
        end
    end

    assign busy_o      = (state_q != DIV_STATE_IDLE);
    assign result_o    = result_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = result_valid_o;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, sign rules, special cases, flush, reset.
module tb_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        busy_o, stall_o, result_valid_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    div_ctrl #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .op_i           (op_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .reg_waddr_i    (reg_waddr_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_we_o       (reg_we_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Captured by run_op: valid cycle, strobe count, busy cycles, data.
    int          r_vcyc, r_nvalid, r_busy;
    logic [31:0] r_res, r_hold;
    logic [4:0]  r_wa;
    logic        r_stall0, r_stall_done, r_we_ok;

    // Inputs change on the falling edge; cycle k is the k-th falling edge after the start edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa);
        @(negedge clk_i);
        op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
        #1 r_stall0 = stall_o;
        r_vcyc = -1; r_nvalid = 0; r_busy = 0; r_res = '0; r_wa = '0;
        r_stall_done = 1'b1; r_we_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (busy_o) r_busy++;
            if (reg_we_o !== result_valid_o) r_we_ok = 1'b0;
            if (result_valid_o) begin
                r_nvalid++; r_vcyc = k; r_res = result_o; r_wa = reg_waddr_o;
                r_stall_done = stall_o;
            end
        end
        r_hold = result_o;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, stall_o, result_valid_o, reg_we_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy_o, stall_o, result_valid_o, reg_we_o});
        end
        checks++;
        if (result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin
            errors++; $display("FAIL reset_data: got res=%h wa=%0d want 0/0", result_o, reg_waddr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(2'b01, 32'd100, 32'd7, 5'd5);
        checks++;
        if (r_stall0 !== 1'b1) begin errors++; $display("FAIL divu_stall_accept: got %b want 1", r_stall0); end
        checks++;
        if (r_vcyc != 33 || r_nvalid != 1 || r_busy != 33) begin
            errors++; $display("FAIL divu_timing: got vcyc=%0d nvalid=%0d busy=%0d want 33/1/33", r_vcyc, r_nvalid, r_busy);
        end
        checks++;
        if (r_res !== 32'd14 || r_wa !== 5'd5) begin
            errors++; $display("FAIL divu_result: got %0d wa=%0d want 14 wa=5", r_res, r_wa);
        end
        checks++;
        if (r_stall_done !== 1'b0 || r_we_ok !== 1'b1) begin
            errors++; $display("FAIL done_stall_we: got stall=%b we_ok=%b want 0/1", r_stall_done, r_we_ok);
        end
        checks++;
        if (r_hold !== 32'd14) begin errors++; $display("FAIL result_hold: got %0d want 14", r_hold); end
        run_op(2'b11, 32'd100, 32'd7, 5'd6);
        checks++;
        if (r_res !== 32'd2 || r_vcyc != 33 || r_wa !== 5'd6) begin
            errors++; $display("FAIL remu_result: got %0d at %0d wa=%0d want 2 at 33 wa=6", r_res, r_vcyc, r_wa);
        end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b00};
        logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7};
        logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFFFFFE};
        logic [31:0] exp [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 10));
            checks++;
            if (r_res !== exp[i] || r_vcyc != 33 || r_nvalid != 1) begin
                errors++; $display("FAIL signed_%0d: got %h at %0d (n=%0d) want %h at 33", i, r_res, r_vcyc, r_nvalid, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 20));
            checks++;
            if (r_res !== exp[i] || r_vcyc != 1 || r_nvalid != 1 || r_busy != 1 || r_wa !== 5'(i + 20)) begin
                errors++; $display("FAIL special_%0d: got %h at %0d busy=%0d wa=%0d want %h at 1", i, r_res, r_vcyc, r_busy, r_wa, exp[i]);
            end
            checks++;
            if (r_stall0 !== 1'b1) begin errors++; $display("FAIL special_stall_%0d: got %b want 1", i, r_stall0); end
        end
    endtask

    task automatic test_flush();
        int nv = 0, vc = -1, nv2 = 0;
        logic [31:0] res = '0;
        logic [4:0] wa = '0;
        @(negedge clk_i);
        op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd3; start_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (k == 10) flush_i = 1'b1;
            #1;
            if (result_valid_o) nv++;
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3; reg_waddr_i = 5'd7; start_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b1 || nv != 0) begin
            errors++; $display("FAIL flush_calc: got busy=%b stall=%b nvalid=%0d want 0/1/0", busy_o, stall_o, nv);
        end
        for (int k = 12; k <= 50; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (result_valid_o) begin nv2++; vc = k; res = result_o; wa = reg_waddr_o; end
        end
        checks++;
        if (vc != 44 || nv2 != 1 || res !== 32'd3 || wa !== 5'd7) begin
            errors++; $display("FAIL flush_restart: got %0d at %0d n=%0d wa=%0d want 3 at 44 wa=7", res, vc, nv2, wa);
        end
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_vs_start_stall: got %b want 0", stall_o); end
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_vs_start_busy: got %b want 0", busy_o); end
        nv = 0;
        op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            flush_i = (k == 33);
            #1;
            if (k == 33) begin
                checks++;
                if (busy_o !== 1'b1 || result_valid_o !== 1'b0 || reg_we_o !== 1'b0) begin
                    errors++; $display("FAIL flush_done: got busy=%b valid=%b we=%b want 1/0/0", busy_o, result_valid_o, reg_we_o);
                end
            end else if (result_valid_o) nv++;
        end
        flush_i = 1'b0;
        checks++;
        if (nv != 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_done_after: got nvalid=%0d busy=%b want 0/0", nv, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        @(negedge clk_i);
        op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd9; start_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || result_o !== 32'h0 || reg_waddr_o !== 5'h0 || result_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got busy=%b res=%h wa=%0d valid=%b want 0", busy_o, result_o, reg_waddr_o, result_valid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            #1;
            if (result_valid_o || busy_o) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL reset_mid_after: got %0d active cycles want 0", nv); end
    endtask

    task automatic test_back_to_back();
        int nv = 0, vc = -1, late_busy = 0;
        logic [31:0] res = '0;
        logic [4:0] wa = '0;
        @(negedge clk_i);
        op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            start_i = (k == 3) || (k == 33);
            if (k == 3) begin op_i = 2'b00; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd9; end
            if (k == 33) begin op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3; reg_waddr_i = 5'd7; end
            #1;
            if (result_valid_o) begin nv++; vc = k; res = result_o; wa = reg_waddr_o; end
            if (k >= 34 && busy_o) late_busy++;
        end
        checks++;
        if (vc != 33 || nv != 1 || res !== 32'd14 || wa !== 5'd5) begin
            errors++; $display("FAIL busy_start: got %0d at %0d n=%0d wa=%0d want 14 at 33 wa=5", res, vc, nv, wa);
        end
        checks++;
        if (late_busy != 0) begin errors++; $display("FAIL done_start: got %0d busy cycles want 0", late_busy); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
